j1_io_interconnect: RTL and testbench

//  Parametrised J1 I/O bus fabric that replaces the fixed page decoder/read mux in the SoC top.

---
 rtl/j1_io_pkg.sv | 31 +++
 rtl/j1_io_page_decode.sv | 30 +++
 rtl/j1_io_interconnect.sv | 251 +++++++++++++++++++++++++
 tb/tb_j1_io_interconnect.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/j1_io_pkg.sv
// Shared definitions for the J1 I/O interconnect: FSM encoding, default
// read value, status page layout and the saturating error-count helper.
package j1_io_pkg;

    // Request FSM states; one transaction walks IDLE -> REQ -> WAIT -> DONE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Value returned on unmapped pages, timeouts and protocol errors.
    localparam logic [15:0] DEFAULT_DIN_C = 16'h0666;

    // Default page map: slot 0 at BASE_PAGE_C, status registers at STAT_PAGE_C.
    localparam logic [7:0] BASE_PAGE_C = 8'h67;
    localparam logic [7:0] STAT_PAGE_C = 8'h7F;

    // Offsets inside the status page.
    localparam logic [7:0] STAT_OFS_CNT  = 8'h00;  // read err_cnt, write clears it
    localparam logic [7:0] STAT_OFS_ADDR = 8'h01;  // read address of last failure

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Error counter increment that sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/j1_io_page_decode.sv
// Combinational page decoder: maps an 8-bit I/O page to a slot hit with its
// slot index, or to the internal status page.
module j1_io_page_decode
    import j1_io_pkg::*;
#(
    parameter int         N_SLAVES  = 8,
    parameter int         SLOT_W    = 3,
    parameter logic [7:0] BASE_PAGE = BASE_PAGE_C,
    parameter logic [7:0] STAT_PAGE = STAT_PAGE_C
) (
    input  logic [7:0]        page,
    output logic              hit,
    output logic [SLOT_W-1:0] slot,
    output logic              stat_hit
);

    localparam logic [8:0] N_SLAVES_9 = 9'(N_SLAVES);

    // Page offset from slot 0, one bit wider so pages below BASE_PAGE cannot alias.
    logic [8:0] rel;

    // Range check against the slot window plus exact match for the status page.
    always_comb begin
        rel      = {1'b0, page} - {1'b0, BASE_PAGE};
        hit      = (page >= BASE_PAGE) && (rel < N_SLAVES_9);
        slot     = rel[SLOT_W-1:0];
        stat_hit = (page == STAT_PAGE);
    end

endmodule

// File: rtl/j1_io_interconnect.sv
// J1 I/O bus fabric: decodes the master's page to one of N_SLAVES slots,
// runs a registered request FSM with per-slave ack and timeout, and serves
// an internal status page holding an error counter and last failing address.
module j1_io_interconnect
    import j1_io_pkg::*;
#(
    parameter int                N_SLAVES    = 8,
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                SADDR_W     = 8,
    parameter logic [7:0]        BASE_PAGE   = BASE_PAGE_C,
    parameter logic [7:0]        STAT_PAGE   = STAT_PAGE_C,
    parameter int                TIMEOUT     = 15,
    parameter logic [DATA_W-1:0] DEFAULT_DIN = DATA_W'(DEFAULT_DIN_C)
) (
    input  logic                         sys_clk_i,
    input  logic                         sys_rst_i,
    // J1 master side
    input  logic                         m_rd,
    input  logic                         m_wr,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_dout,
    output logic [DATA_W-1:0]            m_din,
    output logic                         m_busy,
    output logic                         m_done,
    output logic                         m_err,
    // slave side
    output logic [N_SLAVES-1:0]          s_cs,
    output logic                         s_rd,
    output logic                         s_wr,
    output logic [SADDR_W-1:0]           s_addr,
    output logic [DATA_W-1:0]            s_dout,
    input  logic [N_SLAVES*DATA_W-1:0]   s_din,
    input  logic [N_SLAVES-1:0]          s_ack
);

    localparam int SLOT_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    state_t state_q, state_d;

    // Transaction captured in IDLE
    logic                rd_q, wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   dout_q;
    logic [SLOT_W-1:0]   slot_q;

    // Wait-phase bookkeeping
    logic [7:0]          timer_q;
    logic                ack_pend_q;  // ack already seen during REQ
    logic [DATA_W-1:0]   cap_q;       // read data captured with that early ack

    // Completion and status
    logic                err_q;
    logic [DATA_W-1:0]   din_q;
    logic [7:0]          err_cnt_q;
    logic [ADDR_W-1:0]   err_addr_q;

    // Decode of the live master address
    logic                dec_hit, dec_stat;
    logic [SLOT_W-1:0]   dec_slot;

    logic                strobe;
    logic                sel_ack;
    logic [DATA_W-1:0]   sel_din;
    logic                timeout_hit;
    logic [DATA_W-1:0]   stat_rdata;

    // Completion of the current transaction (asserted on the edge into DONE)
    logic                fin;
    logic                fin_err;
    logic                fin_rd;
    logic                fin_clr;
    logic [ADDR_W-1:0]   fin_addr;
    logic [DATA_W-1:0]   fin_rdata;
    logic                ack_ok;

    j1_io_page_decode #(
        .N_SLAVES  (N_SLAVES),
        .SLOT_W    (SLOT_W),
        .BASE_PAGE (BASE_PAGE),
        .STAT_PAGE (STAT_PAGE)
    ) u_page_decode (
        .page     (m_addr[ADDR_W-1 -: 8]),
        .hit      (dec_hit),
        .slot     (dec_slot),
        .stat_hit (dec_stat)
    );

    assign strobe      = m_rd | m_wr;
    assign sel_ack     = s_ack[slot_q];
    assign sel_din     = s_din[int'(slot_q)*DATA_W +: DATA_W];
    assign timeout_hit = (timer_q == 8'(TIMEOUT - 1));

    // Status page read value, selected by the live offset since status
    // accesses complete straight out of IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        stat_rdata = DEFAULT_DIN;
        if (m_addr[7:0] == STAT_OFS_CNT) begin
            stat_rdata = DATA_W'(err_cnt_q);
        end else if (m_addr[7:0] == STAT_OFS_ADDR) begin
            stat_rdata = DATA_W'(err_addr_q);
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (sys_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; strobes outside IDLE are simply not looked at.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    if ((m_rd && m_wr) || dec_stat || !dec_hit) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (sel_ack || ack_pend_q || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Completion decode: error flag, read result and status-clear request.
    always_comb begin
        fin       = 1'b0;
        fin_err   = 1'b0;
        fin_rd    = 1'b0;
        fin_clr   = 1'b0;
        fin_addr  = addr_q;
        fin_rdata = DEFAULT_DIN;
        ack_ok    = sel_ack || ack_pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (strobe && (state_d == ST_DONE)) begin
                    fin      = 1'b1;
                    fin_rd   = m_rd;
                    fin_addr = m_addr;
                    // Anything finishing from IDLE that is not a clean status access failed.
                    fin_err  = (m_rd && m_wr) || !dec_stat;
                    fin_rdata = fin_err ? DEFAULT_DIN : stat_rdata;
                    fin_clr  = !fin_err && m_wr && (m_addr[7:0] == STAT_OFS_CNT);
                end
            end
            ST_WAIT: begin
                if (state_d == ST_DONE) begin
                    fin     = 1'b1;
                    fin_rd  = rd_q;
                    fin_err = !ack_ok;
                    if (ack_pend_q) begin
                        fin_rdata = cap_q;
                    end else if (sel_ack) begin
                        fin_rdata = sel_din;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath: request capture, timeout timer, read data and error status.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
            slot_q     <= '0;
            timer_q    <= '0;
            ack_pend_q <= 1'b0;
            cap_q      <= '0;
            err_q      <= 1'b0;
            din_q      <= DEFAULT_DIN;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && strobe) begin
                rd_q   <= m_rd;
                wr_q   <= m_wr;
                addr_q <= m_addr;
                dout_q <= m_dout;
                slot_q <= dec_slot;
            end

            // An ack arriving alongside the REQ strobe is remembered and
            // honoured in the first WAIT cycle.
            if (state_q == ST_REQ) begin
                timer_q    <= '0;
                ack_pend_q <= sel_ack;
                cap_q      <= sel_din;
            end else if (state_q == ST_WAIT) begin
                timer_q <= timer_q + 8'd1;
            end

            if (fin) begin
                err_q <= fin_err;
                if (fin_rd) begin
                    din_q <= fin_rdata;
                end
            end

            if (fin_clr) begin
                err_cnt_q <= '0;
            end else if (fin && fin_err) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end

            if (fin && fin_err) begin
                err_addr_q <= fin_addr;
            end
        end
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        m_busy = (state_q != ST_IDLE);
        m_done = (state_q == ST_DONE);
        m_err  = (state_q == ST_DONE) && err_q;
        s_cs   = '0;
        s_rd   = 1'b0;
        s_wr   = 1'b0;
        if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
            s_cs[slot_q] = 1'b1;
        end
        if (state_q == ST_REQ) begin
            s_rd = rd_q;
            s_wr = wr_q;
        end
    end

    assign m_din  = din_q;
    assign s_addr = addr_q[SADDR_W-1:0];
    assign s_dout = dout_q;

endmodule

// File: tb/tb_j1_io_interconnect.sv
// Self-checking bench for j1_io_interconnect: directed scenarios followed by
// randomized transactions against a transaction-level reference model.
module tb_j1_io_interconnect;

    localparam int          N    = 8;
    localparam int          DW   = 16;
    localparam int          AW   = 16;
    localparam int          SW   = 8;
    localparam int          TO   = 15;
    localparam logic [7:0]  BASE = 8'h67;
    localparam logic [7:0]  STAT = 8'h7F;
    localparam logic [15:0] DEF  = 16'h0666;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              m_rd = 1'b0, m_wr = 1'b0;
    logic [AW-1:0]     m_addr = '0;
    logic [DW-1:0]     m_dout = '0;
    logic [DW-1:0]     m_din;
    logic              m_busy, m_done, m_err;
    logic [N-1:0]      s_cs;
    logic              s_rd, s_wr;
    logic [SW-1:0]     s_addr;
    logic [DW-1:0]     s_dout;
    logic [N*DW-1:0]   s_din = '0;
    logic [N-1:0]      s_ack = '0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0]  mdl_cnt;
    logic [15:0] mdl_eaddr;
    logic [15:0] mdl_din;

    j1_io_interconnect #(
        .N_SLAVES (N), .DATA_W (DW), .ADDR_W (AW), .SADDR_W (SW),
        .BASE_PAGE (BASE), .STAT_PAGE (STAT), .TIMEOUT (TO), .DEFAULT_DIN (DEF)
    ) dut (
        .sys_clk_i (clk), .sys_rst_i (rst),
        .m_rd (m_rd), .m_wr (m_wr), .m_addr (m_addr), .m_dout (m_dout),
        .m_din (m_din), .m_busy (m_busy), .m_done (m_done), .m_err (m_err),
        .s_cs (s_cs), .s_rd (s_rd), .s_wr (s_wr), .s_addr (s_addr),
        .s_dout (s_dout), .s_din (s_din), .s_ack (s_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_cnt   = 8'h00;
        mdl_eaddr = 16'h0000;
        mdl_din   = DEF;
    endtask

    // One master transaction, entered and left at a negedge. ack_at is the
    // cycle (1 = REQ, 2 = first WAIT) in which the selected slave acks;
    // hold keeps the strobe asserted for that many extra cycles.
    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input int ack_at, input int hold,
                           input logic [15:0] sdata);
        logic [7:0]  page, ofs;
        logic [15:0] stat_val, ack_data, exp_din;
        logic [7:0]  sel_mask;
        bit          slave, err, is_stat;
        int          slot, done, hold_c;

        page = addr[15:8];
        ofs  = addr[7:0];
        slave = 0; err = 0; is_stat = 0; slot = 0;
        if (rd && wr)                                   err = 1;
        else if (page == STAT)                          is_stat = 1;
        else if (page >= BASE && int'(page) < int'(BASE) + N) begin
            slave = 1;
            slot  = int'(page) - int'(BASE);
        end else                                        err = 1;

        if (!slave) done = 1;
        else if (ack_at <= 2) done = 3;
        else if (ack_at - 2 < TO) done = ack_at + 1;
        else begin
            done = TO + 2;
            err  = 1;
        end
        hold_c = (hold > done) ? done : hold;

        stat_val = (ofs == 8'h00) ? {8'h00, mdl_cnt} : (ofs == 8'h01) ? mdl_eaddr : DEF;
        sel_mask = slave ? 8'(1 << slot) : 8'h00;
        ack_data = 16'hxxxx;

        m_rd   = rd;
        m_wr   = wr;
        m_addr = addr;
        m_dout = wdata;
        s_din  = {$urandom, $urandom, $urandom, $urandom};
        s_din[slot*DW +: DW] = sdata;
        s_ack  = 8'($urandom) & ~sel_mask;

        for (int c = 1; c <= done + 1; c++) begin
            @(negedge clk);
            if (c <= done) begin
                check("busy", m_busy, 1'b1);
                check("done", m_done, (c == done));
                check("s_cs", s_cs, (slave && c < done) ? sel_mask : 8'h00);
                check("s_rd", s_rd, slave && rd && c == 1);
                check("s_wr", s_wr, slave && wr && c == 1);
                if (slave) begin
                    check("s_addr", s_addr, addr[7:0]);
                    check("s_dout", s_dout, wdata);
                end
                if (c == done) begin
                    if (rd) begin
                        exp_din = err ? DEF : (slave ? ack_data : stat_val);
                        mdl_din = exp_din;
                    end
                    check("m_err", m_err, err);
                    check("m_din", m_din, mdl_din);
                end
            end else begin
                check("idle_busy", m_busy, 1'b0);
                check("idle_done", m_done, 1'b0);
                check("din_hold", m_din, mdl_din);
            end

            // Inputs for the edge closing cycle c
            if (c > hold_c) begin
                m_rd = 1'b0;
                m_wr = 1'b0;
            end
            m_addr = 16'($urandom);
            m_dout = 16'($urandom);
            if (c > ack_at) s_din = {$urandom, $urandom, $urandom, $urandom};
            s_ack = 8'($urandom) & ~sel_mask;
            if (slave && c == ack_at && c <= done) begin
                s_ack    = s_ack | sel_mask;
                ack_data = s_din[slot*DW +: DW];
            end
        end
        s_ack = '0;

        if (err) begin
            mdl_cnt   = (mdl_cnt == 8'hFF) ? 8'hFF : mdl_cnt + 8'd1;
            mdl_eaddr = addr;
        end else if (is_stat && wr && ofs == 8'h00) begin
            mdl_cnt = 8'h00;
        end
    endtask

    logic [7:0]  r_page;
    logic [15:0] r_addr;
    int          kind, dsel;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_busy", m_busy, 1'b0);
        check("rst_done", m_done, 1'b0);
        check("rst_err",  m_err,  1'b0);
        check("rst_cs",   s_cs,   8'h00);
        check("rst_srd",  s_rd,   1'b0);
        check("rst_swr",  s_wr,   1'b0);
        check("rst_din",  m_din,  16'h0666);
        rst = 1'b0;
        @(negedge clk);

        // Read slot 2, ack in the third WAIT cycle
        run_txn(1, 0, 16'h6904, 16'h0000, 4, 0, 16'hBEEF);
        check("rd_slot2", m_din, 16'hBEEF);
        // Write slot 0, ack in the first WAIT cycle
        run_txn(0, 1, 16'h6700, 16'h1234, 2, 0, 16'h0000);
        // Ack alongside REQ
        run_txn(1, 0, 16'h6A10, 16'h0000, 1, 0, 16'hCAFE);
        check("rd_early_ack", m_din, 16'hCAFE);
        // Unmapped read, then status registers
        run_txn(1, 0, 16'h5000, 16'h0000, 2, 0, 16'h0000);
        check("unmapped_din", m_din, 16'h0666);
        run_txn(1, 0, 16'h7F00, 16'h0000, 2, 0, 16'h0000);
        check("stat_cnt1", m_din, 16'h0001);
        run_txn(1, 0, 16'h7F01, 16'h0000, 2, 0, 16'h0000);
        check("stat_addr", m_din, 16'h5000);
        // Timeout on slot 0
        run_txn(1, 0, 16'h6733, 16'h0000, 1000, 0, 16'hAAAA);
        check("timeout_din", m_din, 16'h0666);
        // Ack in the last allowed WAIT cycle
        run_txn(1, 0, 16'h6E01, 16'h0000, TO + 1, 0, 16'h5A5A);
        check("late_ack", m_din, 16'h5A5A);
        // Protocol error, then clear and saturate
        run_txn(1, 1, 16'h6800, 16'h0000, 2, 0, 16'h0000);
        run_txn(0, 1, 16'h7F00, 16'h0000, 2, 0, 16'h0000);
        for (int i = 0; i < 256; i++) begin
            run_txn(1, 0, {8'($urandom_range(0, 8'h66)), 8'($urandom)}, 16'h0000, 2, 0, 16'h0000);
        end
        run_txn(1, 0, 16'h7F00, 16'h0000, 2, 0, 16'h0000);
        check("sat_cnt", m_din, 16'h00FF);
        run_txn(0, 1, 16'h7F00, 16'h0000, 2, 0, 16'h0000);
        run_txn(1, 0, 16'h7F00, 16'h0000, 2, 0, 16'h0000);
        check("cleared_cnt", m_din, 16'h0000);
        // Strobe held while busy must not start a second transaction
        run_txn(0, 1, 16'h6B22, 16'h9876, 6, 3, 16'h0000);

        // Reset in WAIT
        m_rd = 1'b1; m_addr = 16'h6700;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            m_rd = 1'b0;
        end
        check("pre_rst_cs", s_cs, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cs",   s_cs,   8'h00);
        check("mid_rst_busy", m_busy, 1'b0);
        check("mid_rst_done", m_done, 1'b0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("post_rst_done", m_done, 1'b0);
        run_txn(1, 0, 16'h6C00, 16'h0000, 3, 0, 16'h7777);
        check("post_rst_rd", m_din, 16'h7777);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6)       r_page = BASE + 8'($urandom_range(0, N - 1));
            else if (kind < 8)  r_page = STAT;
            else if (kind == 8) r_page = 8'($urandom_range(8'h80, 8'hFF));
            else                r_page = 8'($urandom);
            r_addr = {r_page, (kind == 6 || kind == 7) ? 8'($urandom_range(0, 3)) : 8'($urandom)};
            dsel = $urandom_range(0, 9);
            run_txn(dsel < 5 || dsel == 9, dsel >= 5, r_addr, 16'($urandom),
                    $urandom_range(1, 19), $urandom_range(0, 3), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
